// File: rtl/r_triadic_pkg.sv
// Shared constants and FSM state type for the R-type triadic core.
// Also holds the funct decode used to flag illegal instructions.
package r_triadic_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'h00;

  localparam logic [5:0] FN_SLL  = 6'h04;
  localparam logic [5:0] FN_SRL  = 6'h06;
  localparam logic [5:0] FN_SRA  = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [2:0] {StIdle, StLoad, StRead, StExec, StWb} state_e;

  function automatic logic funct_known(input logic [5:0] f);
    logic ok;
    case (f)
      FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_SUB,
      FN_AND, FN_OR, FN_XOR, FN_SLT, FN_SLTU: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/r_triadic_regfile.sv
// Register file: two combinational read ports, one synchronous write port.
// Register 0 is hardwired to zero; writes to it are dropped.
module r_triadic_regfile #(
  parameter int unsigned NREG = 32,
  parameter int unsigned XLEN = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREG)-1:0]  raddr1,
  input  logic [$clog2(NREG)-1:0]  raddr2,
  output logic [XLEN-1:0]          rdata1,
  output logic [XLEN-1:0]          rdata2,
  input  logic                     we,
  input  logic [$clog2(NREG)-1:0]  waddr,
  input  logic [XLEN-1:0]          wdata
);

  logic [XLEN-1:0] mem_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) mem_q[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : mem_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : mem_q[raddr2];

endmodule

// File: rtl/r_triadic_core.sv
// Sequential R-type core: byte-stream instruction fetch, register read,
// ALU execute and writeback, one instruction at a time.
module r_triadic_core
  import r_triadic_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned OUT_W = XLEN / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  input  logic             host_we,
  input  logic [4:0]       host_addr,
  input  logic [XLEN-1:0]  host_wdata,
  input  logic             out_sel,
  output logic [OUT_W-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned SW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [31:0]     ir_q;
  logic [1:0]      cnt_q;
  logic [XLEN-1:0] a_q, b_q, result_q;
  logic            illegal_q;

  logic            accept, dec_illegal, wb_we, host_ok, rf_we;
  logic [AW-1:0]   rs1, rs2, rd, rf_waddr;
  logic [XLEN-1:0] rdata1, rdata2, rf_wdata;
  logic            unused_ir;

  function automatic logic [XLEN-1:0] alu(input logic [5:0] f,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic [SW-1:0]   sh;
    logic [XLEN-1:0] r;
    sh = b[SW-1:0];
    case (f)
      FN_ADD:  r = a + b;
      FN_SUB:  r = a - b;
      FN_AND:  r = a & b;
      FN_OR:   r = a | b;
      FN_XOR:  r = a ^ b;
      FN_SLL:  r = a << sh;
      FN_SRL:  r = a >> sh;
      FN_SRA:  r = $unsigned($signed(a) >>> sh);
      FN_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      FN_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign rs1         = ir_q[21 +: AW];
  assign rs2         = ir_q[16 +: AW];
  assign rd          = ir_q[11 +: AW];
  assign dec_illegal = (ir_q[31:26] != OPC_RTYPE) || !funct_known(ir_q[5:0]);
  assign accept      = in_valid && in_ready;
  assign unused_ir   = ^ir_q[10:6];

  // Host port only reaches the register file when the stream is quiet.
  assign host_ok  = host_we && (state_q == StIdle) && !in_valid;
  assign rf_we    = wb_we || host_ok;
  assign rf_waddr = wb_we ? rd : host_addr[AW-1:0];
  assign rf_wdata = wb_we ? result_q : host_wdata;

  r_triadic_regfile #(
    .NREG (NREG),
    .XLEN (XLEN)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StLoad;
      StLoad:  if (accept && (cnt_q == 2'd3)) state_d = StRead;
      StRead:  state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    wb_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      StLoad: in_ready = 1'b1;
      StWb: begin
        done  = 1'b1;
        wb_we = !dec_illegal;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q      <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (accept) begin
        ir_q[{cnt_q, 3'b000} +: 8] <= in_byte;
        cnt_q                      <= cnt_q + 2'd1;
        if (state_q == StIdle) illegal_q <= 1'b0;
      end
      if (state_q == StRead) begin
        a_q <= rdata1;
        b_q <= rdata2;
      end
      if (state_q == StExec) begin
        result_q <= dec_illegal ? '0 : alu(ir_q[5:0], a_q, b_q);
        if (dec_illegal) illegal_q <= 1'b1;
      end
    end
  end

  assign illegal  = illegal_q;
  assign out_data = out_sel ? result_q[OUT_W-1:0] : result_q[XLEN-1:OUT_W];

endmodule

// File: tb/tb_r_triadic_core.sv
// Self-checking bench for r_triadic_core: fixed vectors, directed corner
// sequences and randomized instructions against a register-level model.
module tb_r_triadic_core;

  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26, F_SLL = 6'h04, F_SRL = 6'h06, F_SRA = 6'h07;
  localparam logic [5:0] F_SLT = 6'h2A, F_SLTU = 6'h2B;
  localparam logic [4:0] PREG  = 5'd1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [7:0]  in_byte;
  logic        host_we;
  logic [4:0]  host_addr;
  logic [31:0] host_wdata;
  logic        out_sel;
  logic [15:0] out_data;
  logic        busy, done, illegal;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mdl [32];
  logic        mdl_ill;

  typedef struct {
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [13];

  logic [5:0] legal_fn [10];

  r_triadic_core #(
    .XLEN  (32),
    .NREG  (32),
    .OUT_W (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_byte    (in_byte),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .out_sel    (out_sel),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] s1,
                                      input logic [4:0] s2, input logic [4:0] d,
                                      input logic [5:0] fn);
    return {op, s1, s2, d, 5'b0, fn};
  endfunction

  function automatic bit fn_ok(input logic [5:0] fn);
    for (int i = 0; i < 10; i++) if (legal_fn[i] == fn) return 1'b1;
    return 1'b0;
  endfunction

  // Reference ALU from arithmetic definitions, independent of the RTL operators.
  function automatic logic [31:0] ref_alu(input logic [5:0] fn, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    logic [31:0] fill;
    sh = int'(b % 32);
    fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
    case (fn)
      F_ADD:   return a + b;
      F_SUB:   return a + (~b + 32'd1);
      F_AND:   return a & b;
      F_OR:    return a | b;
      F_XOR:   return a ^ b;
      F_SLL:   return a * (32'd1 << sh);
      F_SRL:   return a / (32'd1 << sh);
      F_SRA:   return (a / (32'd1 << sh)) | fill;
      F_SLT:   return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      F_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic host_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
    if (a != 5'd0) mdl[a] = d;
  endtask

  // Streams one instruction, waits for retirement and checks it against the model.
  task automatic run_instr(input logic [31:0] ir, input bit gaps, input bit poison,
                           output logic [31:0] obs);
    int          lat;
    bit          legal;
    logic [31:0] exp_res;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1 && mdl_ill) check("illegal_clear", {31'b0, illegal}, 32'd0);
      if (gaps && i > 0) begin
        in_valid = 1'b0;
        if (poison) begin host_we = 1'b1; host_addr = PREG; host_wdata = 32'hDEAD_BEEF; end
        @(negedge clk);
        host_we = 1'b0;
      end
      in_valid = 1'b1;
      in_byte  = ir[8*i +: 8];
      if (poison && i == 0) begin
        host_we = 1'b1; host_addr = PREG; host_wdata = 32'hBAD0_BAD0;
      end else begin
        host_we = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    host_we  = 1'b0;
    legal   = (ir[31:26] == 6'd0) && fn_ok(ir[5:0]);
    exp_res = legal ? ref_alu(ir[5:0], mdl[ir[25:21]], mdl[ir[20:16]]) : 32'd0;
    lat = 0;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("done_latency", lat, 32'd2);
    out_sel = 1'b1; #1; obs[15:0]  = out_data;
    out_sel = 1'b0; #1; obs[31:16] = out_data;
    check("result", obs, exp_res);
    check("illegal", {31'b0, illegal}, {31'b0, !legal});
    if (legal && ir[15:11] != 5'd0) mdl[ir[15:11]] = exp_res;
    mdl_ill = !legal;
    @(negedge clk);
    check("retire_idle", {30'b0, done, busy}, 32'd0);
  endtask

  task automatic peek(input logic [4:0] r);
    logic [31:0] obs;
    run_instr(enc(6'd0, r, 5'd0, 5'd0, F_OR), 1'b0, 1'b0, obs);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] obs;
    logic [31:0] ir;
    logic [5:0]  fn;
    logic [5:0]  op;

    legal_fn = '{F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLL, F_SRL, F_SRA, F_SLT, F_SLTU};
    vecs[0]  = '{F_ADD,  32'h0000_0005, 32'h0000_0003, 32'h0000_0008};
    vecs[1]  = '{F_SUB,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE};
    vecs[2]  = '{F_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234};
    vecs[3]  = '{F_OR,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F};
    vecs[4]  = '{F_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
    vecs[5]  = '{F_SLL,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000};
    vecs[6]  = '{F_SLL,  32'h0000_0003, 32'h0000_0021, 32'h0000_0006};
    vecs[7]  = '{F_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
    vecs[8]  = '{F_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
    vecs[9]  = '{F_SLT,  32'h8000_0000, 32'h0000_0004, 32'h0000_0001};
    vecs[10] = '{F_SLTU, 32'h8000_0000, 32'h0000_0004, 32'h0000_0000};
    vecs[11] = '{F_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[12] = '{F_SRA,  32'h7000_0000, 32'h0000_0004, 32'h0700_0000};

    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    mdl_ill    = 1'b0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_byte    = 8'h00;
    host_we    = 1'b0;
    host_addr  = 5'd0;
    host_wdata = 32'd0;
    out_sel    = 1'b1;
    #12;
    check("reset_ready", {31'b0, in_ready}, 32'd1);
    check("reset_flags", {29'b0, busy, done, illegal}, 32'd0);
    check("reset_out_lo", {16'b0, out_data}, 32'd0);
    out_sel = 1'b0; #1;
    check("reset_out_hi", {16'b0, out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Walkthrough: ADD r3,r1,r2 then SUB r4,r2,r1.
    host_write(5'd1, 32'h0000_0005);
    host_write(5'd2, 32'h0000_0003);
    run_instr(32'h0022_1820, 1'b0, 1'b0, obs);
    check("add_lo", {16'b0, obs[15:0]}, 32'h0000_0008);
    run_instr(enc(6'd0, 5'd2, 5'd1, 5'd4, F_SUB), 1'b0, 1'b0, obs);
    check("sub_hi", {16'b0, obs[31:16]}, 32'h0000_FFFF);
    check("sub_lo", {16'b0, obs[15:0]}, 32'h0000_FFFE);
    peek(5'd3);
    peek(5'd4);

    for (int i = 0; i < 13; i++) begin
      host_write(5'd1, vecs[i].a);
      host_write(5'd2, vecs[i].b);
      run_instr(enc(6'd0, 5'd1, 5'd2, 5'd5, vecs[i].fn), 1'b0, 1'b0, obs);
      check($sformatf("vec%0d", i), obs, vecs[i].exp);
    end

    // r0 stays zero through writeback and host writes.
    run_instr(enc(6'd0, 5'd1, 5'd2, 5'd0, F_ADD), 1'b0, 1'b0, obs);
    host_write(5'd0, 32'h1234_5678);
    peek(5'd0);

    // Illegal opcode and funct, then recovery.
    run_instr(enc(6'h08, 5'd1, 5'd2, 5'd3, F_ADD), 1'b0, 1'b0, obs);
    run_instr(enc(6'd0, 5'd1, 5'd2, 5'd4, 6'h3F), 1'b0, 1'b0, obs);
    peek(5'd3);
    peek(5'd4);

    // Gapped stream with host writes attempted mid-instruction.
    host_write(5'd1, 32'h0000_0005);
    host_write(5'd2, 32'h0000_0003);
    run_instr(32'h0022_1820, 1'b1, 1'b1, obs);
    check("gap_add", obs, 32'h0000_0008);
    peek(PREG);

    // Reset asserted during EXEC drops the pending writeback.
    host_write(5'd1, 32'h0000_0011);
    host_write(5'd2, 32'h0000_0022);
    ir = enc(6'd0, 5'd1, 5'd2, 5'd6, F_ADD);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_byte  = ir[8*i +: 8];
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("busy_exec", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_ready", {31'b0, in_ready}, 32'd1);
    check("rst_flags", {29'b0, busy, done, illegal}, 32'd0);
    check("rst_out", {16'b0, out_data}, 32'd0);
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    mdl_ill = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    peek(5'd6);
    peek(5'd1);
    host_write(5'd1, 32'h0000_0011);
    host_write(5'd2, 32'h0000_0022);
    run_instr(ir, 1'b0, 1'b0, obs);
    check("post_rst_add", obs, 32'h0000_0033);

    // Randomized instruction mix against the model.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0)
        host_write(5'($urandom_range(0, 7)), $urandom);
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 9)];
      ir = enc(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), fn);
      run_instr(ir, 1'($urandom_range(0, 1)), 1'b0, obs);
    end
    for (int r = 1; r < 8; r++) peek(5'(r));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
